// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
// Shared constants and types for the binary-neural-network layer sequencer:
// default layer geometry, arithmetic widths, power-on weights/thresholds and
// the sequencer state type.
// No ports (package).
// ---------------------------------------------------------------------------
package bnn_pkg;

    localparam int NUM_NEURONS = 4;
    localparam int NUM_WEIGHTS = 6;
    localparam int SUM_W       = 3;
    localparam int THRESH_W    = 3;

    localparam logic [5:0] W0_DEFAULT = 6'b111000;
    localparam logic [5:0] W1_DEFAULT = 6'b000111;
    localparam logic [5:0] W2_DEFAULT = 6'b001100;
    localparam logic [5:0] W3_DEFAULT = 6'b110011;

    localparam logic [THRESH_W-1:0] THRESH_DEFAULT = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_e;

    // Power-on weight for neuron n; the four-entry pattern repeats for wider layers.
    function automatic logic [5:0] default_weight(input int unsigned n);
        case (n % 4)
            0:       return W0_DEFAULT;
            1:       return W1_DEFAULT;
            2:       return W2_DEFAULT;
            default: return W3_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/bnn_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// bnn_layer_sequencer_if
// Bundles the configuration, input-vector and result handshakes of the BNN
// layer sequencer.
//   cfg_valid/cfg_ready/cfg_addr/cfg_weight[/cfg_thresh] : per-neuron config write
//   in_valid/in_ready/in_data                            : input vector
//   out_valid/out_ready/out_data                         : result (bit i = neuron i)
//   busy                                                 : sequencer not idle
// Macro BNN_THRESH_LOAD_EN adds cfg_thresh (writable thresholds).
// Modports: slave (the sequencer), master (the driver of the sequencer).
// ---------------------------------------------------------------------------
interface bnn_layer_sequencer_if #(
    parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
    parameter int NUM_WEIGHTS = bnn_pkg::NUM_WEIGHTS
);
    import bnn_pkg::*;

    localparam int ADDR_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [ADDR_W-1:0]      cfg_addr;
    logic [NUM_WEIGHTS-1:0] cfg_weight;
`ifdef BNN_THRESH_LOAD_EN
    logic [THRESH_W-1:0]    cfg_thresh;
`endif
    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_WEIGHTS-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [NUM_NEURONS-1:0] out_data;
    logic                   busy;

    modport slave (
`ifdef BNN_THRESH_LOAD_EN
        input  cfg_thresh,
`endif
        input  cfg_valid, cfg_addr, cfg_weight,
        input  in_valid, in_data,
        input  out_ready,
        output cfg_ready, in_ready, out_valid, out_data, busy
    );

    modport master (
`ifdef BNN_THRESH_LOAD_EN
        output cfg_thresh,
`endif
        output cfg_valid, cfg_addr, cfg_weight,
        output in_valid, in_data,
        output out_ready,
        input  cfg_ready, in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/bnn_layer_sequencer_popcount.sv
// ---------------------------------------------------------------------------
// bnn_popcount
// Combinational XNOR-popcount: counts the bit positions where data and
// weight agree.
//   data   : input vector (NUM_WEIGHTS bits)
//   weight : neuron weight (NUM_WEIGHTS bits)
//   sum    : number of matching bits (SUM_W bits)
// ---------------------------------------------------------------------------
module bnn_popcount #(
    parameter int NUM_WEIGHTS = bnn_pkg::NUM_WEIGHTS,
    parameter int SUM_W       = bnn_pkg::SUM_W
) (
    input  logic [NUM_WEIGHTS-1:0] data,
    input  logic [NUM_WEIGHTS-1:0] weight,
    output logic [SUM_W-1:0]       sum
);
    import bnn_pkg::*;

    logic [NUM_WEIGHTS-1:0] match;

    assign match = ~(data ^ weight);

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_WEIGHTS; i++) begin
            sum = sum + SUM_W'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// bnn_layer_sequencer
// Evaluates one binary-neural-network layer: latches an input vector, then
// runs one neuron per cycle through a single shared XNOR-popcount unit and
// presents the packed result bits on a valid/ready handshake.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : bnn_layer_sequencer_if.slave (cfg, input and result handshakes, busy)
// Macro BNN_THRESH_LOAD_EN: per-neuron thresholds become writable through
// cfg_thresh; otherwise every threshold is the constant THRESH_DEFAULT.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accepts config writes (priority) or an input vector
// COMPUTE | evaluates neuron idx this cycle, result bit stored on the edge
// OUTPUT  | result presented, held until out_ready
// ---------------------------------------------------------------------------
module bnn_layer_sequencer #(
    parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
    parameter int NUM_WEIGHTS = bnn_pkg::NUM_WEIGHTS
) (
    input  logic                 clk,
    input  logic                 reset,
    bnn_layer_sequencer_if.slave bus
);
    import bnn_pkg::*;

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] COMPUTE = ST_COMPUTE;
    localparam logic [1:0] OUTPUT  = ST_OUTPUT;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    logic [1:0]             state;
    logic [IDX_W-1:0]       idx;
    logic [NUM_WEIGHTS-1:0] data_q;
    logic [NUM_NEURONS-1:0] result;
    logic [NUM_WEIGHTS-1:0] weight [NUM_NEURONS];
    logic [SUM_W-1:0]       sum;
    logic [THRESH_W-1:0]    thresh_cur;
    logic                   cfg_fire;
    logic                   in_fire;

    // Config wins a tie with the input, which then stays pending for the next edge.
    assign cfg_fire = (state == IDLE) && bus.cfg_valid;
    assign in_fire  = (state == IDLE) && bus.in_valid && !bus.cfg_valid;

    assign bus.cfg_ready = (state == IDLE);
    assign bus.in_ready  = (state == IDLE) && !bus.cfg_valid;
    assign bus.out_valid = (state == OUTPUT);
    assign bus.out_data  = result;
    assign bus.busy      = (state != IDLE);

    bnn_popcount #(
        .NUM_WEIGHTS (NUM_WEIGHTS),
        .SUM_W       (SUM_W)
    ) u_popcount (
        .data   (data_q),
        .weight (weight[idx]),
        .sum    (sum)
    );

`ifdef BNN_THRESH_LOAD_EN
    logic [THRESH_W-1:0] thresh [NUM_NEURONS];

    assign thresh_cur = thresh[idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                weight[i] <= NUM_WEIGHTS'(default_weight(i));
                thresh[i] <= THRESH_DEFAULT;
            end
        end else if (cfg_fire) begin
            weight[bus.cfg_addr] <= bus.cfg_weight;
            thresh[bus.cfg_addr] <= bus.cfg_thresh;
        end
    end
`else
    assign thresh_cur = THRESH_DEFAULT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                weight[i] <= NUM_WEIGHTS'(default_weight(i));
            end
        end else if (cfg_fire) begin
            weight[bus.cfg_addr] <= bus.cfg_weight;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            data_q <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        data_q <= bus.in_data;
                        idx    <= '0;
                        state  <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    result[idx] <= (sum >= thresh_cur);
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= OUTPUT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bnn_layer_sequencer
// Self-checking bench for bnn_layer_sequencer: a transaction-level model
// (whole result computed with $countones at accept time, plus a latency
// countdown) is compared against the DUT on every falling edge; directed
// sequences pin the model with hand-computed results; a randomized phase
// follows. Honours BNN_THRESH_LOAD_EN.
// ---------------------------------------------------------------------------
module tb_bnn_layer_sequencer;
    import bnn_pkg::*;

    localparam int NN = 4;
    localparam int NW = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks   = 0;
    int failures = 0;

    bnn_layer_sequencer_if #(.NUM_NEURONS(NN), .NUM_WEIGHTS(NW)) bus ();

    bnn_layer_sequencer #(.NUM_NEURONS(NN), .NUM_WEIGHTS(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [NW-1:0] m_w [NN];
    logic [2:0]    m_t [NN];
    int            m_left = 0;
    logic          m_out  = 1'b0;
    logic [NN-1:0] m_exp  = '0;
    logic          m_idle;

    function automatic logic [NN-1:0] predict(input logic [NW-1:0] d);
        logic [NN-1:0] r;
        for (int i = 0; i < NN; i++) begin
            r[i] = ($countones(~(d ^ m_w[i])) >= int'(m_t[i]));
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0;
            m_out  = 1'b0;
            m_w[0] = 6'b111000;
            m_w[1] = 6'b000111;
            m_w[2] = 6'b001100;
            m_w[3] = 6'b110011;
            for (int i = 0; i < NN; i++) m_t[i] = 3'd2;
        end else if (m_out) begin
            if (bus.out_ready) m_out = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_out = 1'b1;
        end else if (bus.cfg_valid) begin
            m_w[bus.cfg_addr] = bus.cfg_weight;
`ifdef BNN_THRESH_LOAD_EN
            m_t[bus.cfg_addr] = bus.cfg_thresh;
`endif
        end else if (bus.in_valid) begin
            m_exp  = predict(bus.in_data);
            m_left = NN;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        m_idle = !m_out && (m_left == 0);
        chk("mdl_out_valid", 32'(bus.out_valid), 32'(m_out));
        chk("mdl_busy",      32'(bus.busy),      32'(!m_idle));
        chk("mdl_cfg_ready", 32'(bus.cfg_ready), 32'(m_idle));
        chk("mdl_in_ready",  32'(bus.in_ready),  32'(m_idle && !bus.cfg_valid));
        if (m_out) chk("mdl_out_data", 32'(bus.out_data), 32'(m_exp));
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_slot();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.cfg_valid = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    task automatic do_reset();
        drive_slot();
        reset = 1'b1;
        idle_inputs();
        bus.out_ready = 1'b0;
        drive_slot();
        drive_slot();
        reset = 1'b0;
    endtask

    task automatic infer(input logic [NW-1:0] d, input logic [NN-1:0] exp, input string name);
        drive_slot();
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = 1'b0;
        drive_slot();
        bus.in_valid = 1'b0;
        for (int k = 0; k < NN; k++) begin
            @(negedge clk);
            chk({name, "_latency"}, 32'(bus.out_valid), 32'd0);
        end
        @(negedge clk);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_data"},  32'(bus.out_data),  32'(exp));
    endtask

    task automatic release_out(input string name);
        drive_slot();
        idle_inputs();
        bus.out_ready = 1'b1;
        drive_slot();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_released_valid"}, 32'(bus.out_valid), 32'd0);
        chk({name, "_released_busy"},  32'(bus.busy),      32'd0);
    endtask

`ifdef BNN_THRESH_LOAD_EN
    task automatic cfg_write(input logic [1:0] a, input logic [NW-1:0] w, input logic [2:0] t);
        drive_slot();
        bus.cfg_valid  = 1'b1;
        bus.cfg_addr   = a;
        bus.cfg_weight = w;
        bus.cfg_thresh = t;
        drive_slot();
        bus.cfg_valid = 1'b0;
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        bus.cfg_valid  = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_weight = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
`ifdef BNN_THRESH_LOAD_EN
        bus.cfg_thresh = '0;
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        drive_slot();
        reset = 1'b0;

        // default weights and thresholds
        infer(6'b111000, 4'b1101, "default");

        // result held while out_ready stays low, even with traffic offered
        for (int k = 0; k < 10; k++) begin
            drive_slot();
            bus.cfg_valid  = 1'b1;
            bus.cfg_addr   = 2'($urandom_range(0, 3));
            bus.cfg_weight = 6'($urandom);
            bus.in_valid   = 1'b1;
            bus.in_data    = 6'($urandom);
            @(negedge clk);
            chk("hold_data",      32'(bus.out_data),  32'h0000000d);
            chk("hold_valid",     32'(bus.out_valid), 32'd1);
            chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
            chk("hold_cfg_ready", 32'(bus.cfg_ready), 32'd0);
            chk("hold_busy",      32'(bus.busy),      32'd1);
        end
        release_out("hold");

        // config and input offered together: config first, input next edge
        drive_slot();
        bus.cfg_valid  = 1'b1;
        bus.cfg_addr   = 2'd0;
        bus.cfg_weight = 6'b000000;
`ifdef BNN_THRESH_LOAD_EN
        bus.cfg_thresh = 3'd2;
`endif
        bus.in_valid   = 1'b1;
        bus.in_data    = 6'b111111;
        drive_slot();
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        chk("collide_busy_after_cfg", 32'(bus.busy),     32'd0);
        chk("collide_in_ready",       32'(bus.in_ready), 32'd1);
        drive_slot();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("collide_busy_after_in", 32'(bus.busy), 32'd1);
        repeat (NN - 1) begin
            @(negedge clk);
            chk("collide_latency", 32'(bus.out_valid), 32'd0);
        end
        @(negedge clk);
        chk("collide_valid", 32'(bus.out_valid), 32'd1);
        chk("collide_data",  32'(bus.out_data),  32'h0000000e);
        release_out("collide");

        // reset during the second compute cycle discards the inference
        drive_slot();
        bus.in_valid = 1'b1;
        bus.in_data  = 6'b111000;
        drive_slot();
        bus.in_valid = 1'b0;
        drive_slot();
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_busy",      32'(bus.busy),      32'd0);
        drive_slot();
        drive_slot();
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_result", 32'(bus.out_valid), 32'd0);
        end
        infer(6'b111000, 4'b1101, "weights_restored");
        release_out("weights_restored");

`ifdef BNN_THRESH_LOAD_EN
        cfg_write(2'd1, 6'b111000, 3'd6);
        infer(6'b111000, 4'b1111, "thresh_load");
        release_out("thresh_load");
        do_reset();
        cfg_write(2'd2, 6'b001100, 3'd0);
        infer(6'b000000, 4'b1111, "thresh_zero");
        release_out("thresh_zero");
        cfg_write(2'd2, 6'b001100, 3'd7);
        infer(6'b000000, 4'b1011, "thresh_seven");
        release_out("thresh_seven");
`endif

        // randomized traffic, including occasional asynchronous resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            drive_slot();
            reset          = ($urandom_range(0, 299) == 0);
            bus.cfg_valid  = ($urandom_range(0, 5) == 0);
            bus.cfg_addr   = 2'($urandom_range(0, 3));
            bus.cfg_weight = 6'($urandom);
`ifdef BNN_THRESH_LOAD_EN
            bus.cfg_thresh = 3'($urandom_range(0, 7));
`endif
            bus.in_valid   = ($urandom_range(0, 1) == 1);
            bus.in_data    = 6'($urandom);
            bus.out_ready  = ($urandom_range(0, 2) != 0);
        end

        drive_slot();
        reset = 1'b0;
        idle_inputs();
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bnn_layer_sequencer.md
BNN_LAYER_SEQUENCER -- requirements
Module: bnn_layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4, meaning the number of neurons evaluated per inference.
REQ-002 SHALL have parameter NUM_WEIGHTS, default 6, meaning the input vector width and the weight width per neuron.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cfg_valid, input, 1 bit: a configuration write is offered.
REQ-006 SHALL have port cfg_ready, output, 1 bit: a configuration write can be accepted.
REQ-007 SHALL have port cfg_addr, input, log2(NUM_NEURONS) bits: the target neuron index.
REQ-008 SHALL have port cfg_weight, input, NUM_WEIGHTS bits: the weight to write.
REQ-009 SHALL have port cfg_thresh, input, 3 bits: the threshold to write (present only with BNN_THRESH_LOAD_EN).
REQ-010 SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit) and in_data (input, NUM_WEIGHTS bits) forming the input vector handshake.
REQ-011 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and out_data (output, NUM_NEURONS bits) forming the result handshake; out_data bit i is neuron i.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, COMPUTE and OUTPUT.
REQ-014 IDLE: cfg_ready=1; in_ready = !cfg_valid; a transfer occurs when valid and ready are both high at a rising edge.
REQ-015 A cfg transfer SHALL write weight[cfg_addr] (and thresh[cfg_addr] with the macro); the new values are used by any inference accepted on a later edge.
REQ-016 Simultaneous cfg_valid and in_valid in IDLE: cfg SHALL win; the input stays pending and is accepted on the next edge.
REQ-017 An input transfer SHALL latch in_data, set neuron index idx=0 and go to COMPUTE.
REQ-018 COMPUTE SHALL evaluate one neuron per cycle through one shared XNOR-popcount unit: sum = popcount(data XNOR weight[idx]), range 0..6 in 3 bits with no overflow.
REQ-019 The result bit SHALL be (sum >= thresh[idx]), unsigned 3-bit compare, stored to result[idx]; idx increments each cycle.
REQ-020 When idx == NUM_NEURONS-1, COMPUTE SHALL go to OUTPUT on that edge.
REQ-021 out_valid SHALL go high exactly NUM_NEURONS rising edges after the input-accept edge (4 with defaults).
REQ-022 OUTPUT: out_valid=1 and out_data held stable until out_ready; on that edge go to IDLE; no back-to-back bypass.
REQ-023 In COMPUTE and OUTPUT, cfg_ready=0 and in_ready=0; weights never change mid-inference.
REQ-024 A threshold of 0 SHALL always fire; a threshold of 7 SHALL never fire.

Reset
REQ-025 Reset SHALL apply asynchronously and be released synchronously to clk.
REQ-026 Reset values: state=IDLE, idx=0, result=0, out_valid=0, busy=0, cfg_ready=1, in_ready=1.
REQ-027 Reset values of the weights SHALL be w0=6'b111000, w1=6'b000111, w2=6'b001100, w3=6'b110011.
REQ-028 Reset value of every threshold SHALL be 3'd2.
REQ-029 Reset mid-COMPUTE or mid-OUTPUT SHALL discard the partial or pending result, with no out_valid afterwards.

Configuration
REQ-030 With BNN_THRESH_LOAD_EN defined, cfg_thresh SHALL exist and thresholds are writable per REQ-015.
REQ-031 Without BNN_THRESH_LOAD_EN, cfg_thresh SHALL be absent and thresholds SHALL be constant 3'd2, with no threshold storage.

Structure
REQ-032 Package bnn_pkg SHALL hold NUM_NEURONS, NUM_WEIGHTS, SUM_W=3, THRESH_W=3, the default weight and threshold constants, and the state enum type.
REQ-033 There SHALL be one combinational sub-module, bnn_popcount (NUM_WEIGHTS-bit data and weight in, SUM_W-bit sum out), instantiated once.

Verification
REQ-034 After reset, in_data=6'b111000 accepted -> out_valid 4 edges later with out_data=4'b1101.
REQ-035 (macro on) Write cfg_addr=1, weight 6'b111000, thresh 6, then in_data=6'b111000 -> out_data=4'b1111.
REQ-036 Hold out_ready=0 for 10 cycles in OUTPUT -> out_data stable, in_ready=0, cfg_ready=0, busy=1; after out_ready=1 for one edge -> IDLE, out_valid=0.
REQ-037 cfg_valid and in_valid asserted together in IDLE (addr 0, weight 0) -> cfg accepted first, input accepted next edge, out_data[0] computed with weight 0.
REQ-038 Assert reset at the 2nd COMPUTE cycle -> immediately out_valid=0 and busy=0, weights restored to defaults, no result emitted.
REQ-039 (macro on) Thresholds 0 and 7 on neuron 2 with in_data=6'b000000 -> bit2=1 for threshold 0 and bit2=0 for threshold 7.
